rgb_fader: RTL and testbench
============================

Name: rgb_fader

Overview:
- Colour-fade engine between the register bank PWM config (pwm_cfg red/green/blue targets) and the three pwm instances.
- Ramps each channel's duty cycle from its current value toward the programmed target in programmable steps at a programmable rate.
- I2C colour writes produce smooth LED transitions instead of hard jumps.
- Instantiated in minivan; outputs drive pwm duty_cycle inputs directly.

Parameters:
- DW, 8, duty width per channel; must match pwm duty_cycle width.
- PRESCALE_W, 16, width of step_div and of the internal prescaler counter.

Ports:
- clk  input  1  system clock.
- resetb  input  1  synchronous, active-low reset; clock clk.
- ena  input  1  top-level enable; 0 freezes all state.
- fade_en  input  1  1 = ramp to target; 0 = outputs follow targets directly.
- target_red  input  DW  red target duty (pwm_cfg.pwm_red).
- target_green  input  DW  green target duty.
- target_blue  input  DW  blue target duty.
- step_div  input  PRESCALE_W  clk cycles per step minus 1.
- step_size  input  4  duty increment per step; 0 is treated as 1.
- duty_red  output  DW  red duty to pwm_red.
- duty_green  output  DW  green duty to pwm_green.
- duty_blue  output  DW  blue duty to pwm_blue.
- busy  output  1  high while in FADE.
- done_pulse  output  1  one-cycle pulse on FADE->IDLE.

Behaviour:
- Reset (resetb=0 at posedge clk): duty_* = 0, state IDLE, prescaler = 0, busy = 0, done_pulse = 0. Reset overrides ena and aborts any fade in progress.
- ena=0: all registers hold (duties, state, prescaler); done_pulse forced 0. Resumes exactly where it stopped.
- Prescaler:
  - Counts 0..step_div; tick asserts in the cycle where count==step_div, then count wraps to 0.
  - step_div=0 gives a tick every cycle.
  - Counts only in FADE; cleared to 0 in IDLE.
- State IDLE:
  - fade_en=0: duty_* <= target_* each cycle (1-cycle latency).
  - fade_en=1 and any duty != target: go to FADE at the next edge, prescaler = 0; duties unchanged on that edge.
- State FADE, per channel on tick:
  - diff = target - duty, computed in DW+1 signed bits.
  - If |diff| <= step, duty <= target; else duty moves toward target by step.
  - No wrap-around: duty never passes target, so it stays within 0..2^DW-1.
- FADE exit: when all three duties equal their targets (evaluated on registered duty vs live target), go to IDLE with done_pulse=1 for that one cycle.
- Retarget mid-fade: targets are sampled live every cycle. A tick in the same cycle as a target change uses the new target. No restart; the ramp continues from the current duty.
- If a retarget makes all channels equal without a tick, the state still exits with done_pulse.
- fade_en falling during FADE:
  - Next edge: duty_* <= target_*, state IDLE, done_pulse=1.
  - Prescaler cleared.
- busy = (state==FADE), registered, no combinational paths from inputs.
- All outputs registered.

Optional Feature:
- Macro FADER_GAMMA_EN.
- Defined:
  - Each linear duty passes through a registered 2.2-gamma lookup (256 entries, DW=8) before duty_* output; adds 1 cycle latency.
  - busy/done_pulse are delayed one cycle to stay aligned with the outputs.
  - Lookup entries: 0->0, 255->255, and the table is monotonic.
- Not defined: duty_* are the linear registers directly, with no LUT logic.

Decomposition:
- minivan_pkg:
  - fader_state_t enum {FADER_IDLE, FADER_FADE}.
  - FADER_DW = 8.
  - FADER_PRESCALE_W = 16.
  - Gamma table constant, under FADER_GAMMA_EN.
- Sub-module fader_channel:
  - Instantiated 3x.
  - Holds one duty register and the step/compare arithmetic.
  - Inputs: tick, load, target, step; outputs: duty, at_target.
- rgb_fader holds the prescaler, the FSM and the optional gamma stage.

Test Plan:
1. Reset: resetb=0 for 2 cycles with targets 0xFF and ena=1 -> all duty_*=0, busy=0, done_pulse=0. Release -> still 0 while fade_en=1 until the fade starts.
2. Direct mode: fade_en=0, target_red=0x80 -> duty_red=0x80 exactly 1 cycle later; busy stays 0.
3. Basic fade: fade_en=1, step_div=2, step_size=4, target_green 0x00->0x10 -> FADE, tick every 3 cycles, duty_green 0x04,0x08,0x0C,0x10; done_pulse one cycle after reaching 0x10; busy drops the same cycle.
4. Partial last step and downward ramp:
   - step_size=3, step_div=0, target_blue 0x00->0x0A -> duty_blue 3,6,9,0x0A.
   - Then target 0x00 -> 7,4,1,0; no underflow.
5. Mid-fade change: ramp red 0x00->0x40 (step 8, div 0); at duty_red=0x18 set target 0x10 -> next tick 0x10, done_pulse. Drop fade_en mid-fade -> duties jump to targets next cycle, done_pulse=1.
6. Freeze: ena=0 for 10 cycles mid-fade -> duties and busy hold constant; ena=1 -> ramp resumes with the same remaining step count.

Source files
------------

// File: rtl/minivan_pkg.sv
// minivan_pkg: shared types and constants for the minivan colour path.
//   fader_state_t    : rgb_fader FSM state encoding (IDLE / FADE).
//   FADER_DW         : duty width per PWM channel.
//   FADER_PRESCALE_W : width of the fade step prescaler.
//   FADER_GAMMA_LUT  : 2.2-gamma table (8-bit in, 8-bit out); only present
//                      when FADER_GAMMA_EN is defined.
package minivan_pkg;

    localparam int FADER_DW         = 8;
    localparam int FADER_PRESCALE_W = 16;

    typedef enum logic [0:0] {
        FADER_IDLE = 1'b0,
        FADER_FADE = 1'b1
    } fader_state_t;

`ifdef FADER_GAMMA_EN
    typedef logic [7:0] fader_gamma_lut_t [256];

    // x^2.2 approximated as 0.8*x^2 + 0.2*x^3 on a 0..255 scale. Integer
    // math keeps it elaboration-constant; 0->0, 255->255, monotonic.
    function automatic fader_gamma_lut_t fader_gamma_build();
        fader_gamma_lut_t lut;
        for (int unsigned x = 0; x < 256; x++) begin
            lut[x] = 8'((4 * x * x * 255 + x * x * x) / (5 * 255 * 255));
        end
        return lut;
    endfunction

    localparam fader_gamma_lut_t FADER_GAMMA_LUT = fader_gamma_build();
`endif

endpackage

// File: rtl/rgb_fader_channel.sv
// fader_channel: one colour channel of rgb_fader. Holds the duty register
// and moves it toward the live target by 'step' on each tick, clamping to
// the target so the duty never overshoots or wraps.
// Ports:
//   clk, resetb : clock, synchronous active-low reset (duty -> 0)
//   tick        : apply one ramp step this cycle
//   load        : copy target into duty this cycle (takes priority)
//   target      : target duty (live)
//   step        : step magnitude, already non-zero
//   duty        : registered duty
//   at_target   : registered duty equals live target
module fader_channel
    import minivan_pkg::*;
#(
    parameter int DW = FADER_DW
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          tick,
    input  logic          load,
    input  logic [DW-1:0] target,
    input  logic [3:0]    step,
    output logic [DW-1:0] duty,
    output logic          at_target
);

    logic [DW-1:0]        duty_q, duty_d;
    logic signed [DW:0]   diff;
    logic [DW:0]          mag;
    logic [DW:0]          step_ext;

    always_comb begin
        diff     = $signed({1'b0, target}) - $signed({1'b0, duty_q});
        // |diff| <= 2^DW-1, so the negation cannot overflow DW+1 bits.
        mag      = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);
        step_ext = (DW+1)'(step);
        duty_d   = duty_q;
        if (load) begin
            duty_d = target;
        end else if (tick) begin
            if (mag <= step_ext) begin
                duty_d = target;
            end else if (diff[DW]) begin
                duty_d = duty_q - DW'(step);
            end else begin
                duty_d = duty_q + DW'(step);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty      = duty_q;
    assign at_target = (duty_q == target);

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader: colour-fade engine between the PWM config registers and the
// three pwm instances. Ramps each channel's duty toward its target by
// step_size every (step_div+1) clocks while fade_en=1; with fade_en=0 the
// duties follow the targets with one cycle of latency.
// Optional macro: FADER_GAMMA_EN adds a registered 2.2-gamma lookup on the
// duty outputs (DW must be 8) and delays busy/done_pulse to match.
// Ports:
//   clk, resetb        : clock, synchronous active-low reset
//   ena                : 0 freezes all state, done_pulse forced low
//   fade_en            : 1 ramp, 0 direct follow
//   target_red/green/blue : live target duties
//   step_div           : clocks per step minus 1
//   step_size          : duty step, 0 treated as 1
//   duty_red/green/blue: registered duties to the pwm instances
//   busy               : registered, high while fading
//   done_pulse         : one-cycle pulse on fade completion/abort
module rgb_fader
    import minivan_pkg::*;
#(
    parameter int DW         = FADER_DW,
    parameter int PRESCALE_W = FADER_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  ena,
    input  logic                  fade_en,
    input  logic [DW-1:0]         target_red,
    input  logic [DW-1:0]         target_green,
    input  logic [DW-1:0]         target_blue,
    input  logic [PRESCALE_W-1:0] step_div,
    input  logic [3:0]            step_size,
    output logic [DW-1:0]         duty_red,
    output logic [DW-1:0]         duty_green,
    output logic [DW-1:0]         duty_blue,
    output logic                  busy,
    output logic                  done_pulse
);

    fader_state_t          state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  busy_q, done_q, done_d;
    logic                  tick_d, load_d, ch_tick, ch_load;
    logic [3:0]            step_eff;
    logic [DW-1:0]         lin_red, lin_green, lin_blue;
    logic                  at_red, at_green, at_blue, all_at;

    assign step_eff = (step_size == 4'd0) ? 4'd1 : step_size;
    assign all_at   = at_red & at_green & at_blue;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        load_d  = 1'b0;
        case (state_q)
            FADER_IDLE: begin
                presc_d = '0;
                if (!fade_en) begin
                    load_d = 1'b1;
                end else if (!all_at) begin
                    state_d = FADER_FADE;
                end
            end
            FADER_FADE: begin
                if (!fade_en) begin
                    load_d  = 1'b1;
                    state_d = FADER_IDLE;
                    done_d  = 1'b1;
                    presc_d = '0;
                end else if (all_at) begin
                    // Also covers a retarget that lands on the current duties.
                    state_d = FADER_IDLE;
                    done_d  = 1'b1;
                    presc_d = '0;
                end else if (presc_q == step_div) begin
                    tick_d  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = FADER_IDLE;
        endcase
    end

    // Channels have no enable of their own; freezing is done by gating here.
    assign ch_tick = tick_d & ena;
    assign ch_load = load_d & ena;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= FADER_IDLE;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            presc_q <= presc_d;
            busy_q  <= (state_d == FADER_FADE);
            done_q  <= done_d;
        end else begin
            done_q  <= 1'b0;
        end
    end

    fader_channel #(.DW(DW)) u_red (
        .clk       (clk),
        .resetb    (resetb),
        .tick      (ch_tick),
        .load      (ch_load),
        .target    (target_red),
        .step      (step_eff),
        .duty      (lin_red),
        .at_target (at_red)
    );

    fader_channel #(.DW(DW)) u_green (
        .clk       (clk),
        .resetb    (resetb),
        .tick      (ch_tick),
        .load      (ch_load),
        .target    (target_green),
        .step      (step_eff),
        .duty      (lin_green),
        .at_target (at_green)
    );

    fader_channel #(.DW(DW)) u_blue (
        .clk       (clk),
        .resetb    (resetb),
        .tick      (ch_tick),
        .load      (ch_load),
        .target    (target_blue),
        .step      (step_eff),
        .duty      (lin_blue),
        .at_target (at_blue)
    );

`ifdef FADER_GAMMA_EN
    logic [DW-1:0] gam_red_q, gam_green_q, gam_blue_q;
    logic          busy_g_q, done_g_q;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            gam_red_q   <= '0;
            gam_green_q <= '0;
            gam_blue_q  <= '0;
            busy_g_q    <= 1'b0;
            done_g_q    <= 1'b0;
        end else if (ena) begin
            gam_red_q   <= FADER_GAMMA_LUT[lin_red];
            gam_green_q <= FADER_GAMMA_LUT[lin_green];
            gam_blue_q  <= FADER_GAMMA_LUT[lin_blue];
            busy_g_q    <= busy_q;
            done_g_q    <= done_q;
        end else begin
            done_g_q    <= 1'b0;
        end
    end

    assign duty_red   = gam_red_q;
    assign duty_green = gam_green_q;
    assign duty_blue  = gam_blue_q;
    assign busy       = busy_g_q;
    assign done_pulse = done_g_q;
`else
    assign duty_red   = lin_red;
    assign duty_green = lin_green;
    assign duty_blue  = lin_blue;
    assign busy       = busy_q;
    assign done_pulse = done_q;
`endif

endmodule

// File: tb/tb_rgb_fader.sv
module tb_rgb_fader;

  logic        clk = 1'b0;
  logic        resetb;
  logic        ena;
  logic        fade_en;
  logic [7:0]  target_red, target_green, target_blue;
  logic [15:0] step_div;
  logic [3:0]  step_size;
  logic [7:0]  duty_red, duty_green, duty_blue;
  logic        busy, done_pulse;

  typedef struct {
    int         cyc;
    int         tag;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       bz;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  rgb_fader #(.DW(8), .PRESCALE_W(16)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .ena          (ena),
    .fade_en      (fade_en),
    .target_red   (target_red),
    .target_green (target_green),
    .target_blue  (target_blue),
    .step_div     (step_div),
    .step_size    (step_size),
    .duty_red     (duty_red),
    .duty_green   (duty_green),
    .duty_blue    (duty_blue),
    .busy         (busy),
    .done_pulse   (done_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc || duty_red !== e.r || duty_green !== e.g ||
          duty_blue !== e.b || busy !== e.bz || done_pulse !== e.dn) begin
        n_fail++;
        $display("FAIL test%0d cyc%0d (due %0d): got r=%h g=%h b=%h busy=%b done=%b, required r=%h g=%h b=%h busy=%b done=%b",
                 e.tag, cyc, e.cyc, duty_red, duty_green, duty_blue, busy, done_pulse,
                 e.r, e.g, e.b, e.bz, e.dn);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic exp(input int k, input int tag, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b,
                     input logic bz, input logic dn);
    exp_t x;
    x.cyc = cyc + k; x.tag = tag;
    x.r = r; x.g = g; x.b = b; x.bz = bz; x.dn = dn;
    sb.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] blue_up [5];
    logic [7:0] blue_dn [5];
    blue_up = '{8'h00, 8'h03, 8'h06, 8'h09, 8'h0A};
    blue_dn = '{8'h0A, 8'h07, 8'h04, 8'h01, 8'h00};

    // 1: reset with targets at full scale
    resetb = 1'b0; ena = 1'b1; fade_en = 1'b1;
    target_red = 8'hFF; target_green = 8'hFF; target_blue = 8'hFF;
    step_div = 16'd0; step_size = 4'd0;
    steps(2);
    n_chk++;
    if (duty_red !== 8'h00 || duty_green !== 8'h00 || duty_blue !== 8'h00 ||
        busy !== 1'b0 || done_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL test1 reset: got r=%h g=%h b=%h busy=%b done=%b",
               duty_red, duty_green, duty_blue, busy, done_pulse);
    end
    exp(0, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    resetb = 1'b1;
    exp(1, 1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    fade_en = 1'b0;
    target_red = 8'h00; target_green = 8'h00; target_blue = 8'h00;
    exp(1, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step();

    // 2: direct mode
    target_red = 8'h80;
    exp(1, 2, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    n_chk++;
    if (duty_red !== 8'h80 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL test2 direct: got r=%h busy=%b, required r=80 busy=0",
               duty_red, busy);
    end
    exp(1, 2, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
    step();

    // 3: basic fade, div 2, step 4, green 0x00 -> 0x10
    fade_en = 1'b1; step_div = 16'd2; step_size = 4'd4; target_green = 8'h10;
    for (int unsigned k = 1; k <= 13; k++)
      exp(k, 3, 8'h80, 8'(4 * ((k - 1) / 3)), 8'h00, 1'b1, 1'b0);
    exp(14, 3, 8'h80, 8'h10, 8'h00, 1'b0, 1'b1);
    exp(15, 3, 8'h80, 8'h10, 8'h00, 1'b0, 1'b0);
    steps(15);

    // 4: partial last step up, then downward ramp without underflow
    step_size = 4'd3; step_div = 16'd0; target_blue = 8'h0A;
    for (int unsigned k = 1; k <= 5; k++)
      exp(k, 4, 8'h80, 8'h10, blue_up[k-1], 1'b1, 1'b0);
    exp(6, 4, 8'h80, 8'h10, 8'h0A, 1'b0, 1'b1);
    steps(6);
    target_blue = 8'h00;
    for (int unsigned k = 1; k <= 5; k++)
      exp(k, 4, 8'h80, 8'h10, blue_dn[k-1], 1'b1, 1'b0);
    exp(6, 4, 8'h80, 8'h10, 8'h00, 1'b0, 1'b1);
    steps(6);

    // 5: retarget mid-fade, then fade_en drop mid-fade
    fade_en = 1'b0; target_red = 8'h00;
    exp(1, 5, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
    step();
    fade_en = 1'b1; target_red = 8'h40; step_size = 4'd8; step_div = 16'd0;
    exp(1, 5, 8'h00, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(2, 5, 8'h08, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(3, 5, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(4, 5, 8'h18, 8'h10, 8'h00, 1'b1, 1'b0);
    steps(4);
    target_red = 8'h10;
    exp(1, 5, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(2, 5, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
    steps(2);
    target_red = 8'h40;
    exp(1, 5, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(2, 5, 8'h18, 8'h10, 8'h00, 1'b1, 1'b0);
    steps(2);
    fade_en = 1'b0;
    exp(1, 5, 8'h40, 8'h10, 8'h00, 1'b0, 1'b1);
    step();

    // 6: freeze mid-fade with ena=0, then resume
    fade_en = 1'b1; target_red = 8'h00; step_div = 16'd1;
    exp(1, 6, 8'h40, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(2, 6, 8'h40, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(3, 6, 8'h38, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(4, 6, 8'h38, 8'h10, 8'h00, 1'b1, 1'b0);
    exp(5, 6, 8'h30, 8'h10, 8'h00, 1'b1, 1'b0);
    steps(5);
    ena = 1'b0;
    for (int unsigned k = 1; k <= 10; k++)
      exp(k, 6, 8'h30, 8'h10, 8'h00, 1'b1, 1'b0);
    steps(10);
    ena = 1'b1;
    for (int unsigned k = 1; k <= 12; k++)
      exp(k, 6, 8'(8'h30 - 8 * (k / 2)), 8'h10, 8'h00, 1'b1, 1'b0);
    exp(13, 6, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1);
    exp(14, 6, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
    steps(14);

    for (int unsigned i = 0; i < 20 && sb.size() != 0; i++) step();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL test%0d drain: expectation for cycle %0d never compared, now cycle %0d",
               e.tag, e.cyc, cyc);
    end

    if (n_fail != 0 || n_chk < 12)
      $display("FAIL summary: %0d checks, %0d failures", n_chk, n_fail);
    else
      $display("PASS summary: %0d checks", n_chk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
